regfile_write_arbiter: RTL

- Shares the single write port of the 32 x 64-bit register file between two writeback requesters (port A, port B) using round-robin arbitration.
- Each requester has a valid/ready handshake and a one-entry holding buffer.
- The block decodes the 5-bit destination into the file's 32-bit one-hot write enable and drives the write data, both registered.
- It suppresses writes to the hardwired-zero register and publishes a pending-write scoreboard for hazard checks.

---
 rtl/regfile_write_arbiter.sv | 76 +++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin sharing of the register-file write port between two buffered requesters
module regfile_write_arbiter #(
    parameter int DATA_W   = 64,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                a_valid,
    output logic                a_ready,
    input  logic [ADDR_W-1:0]   a_addr,
    input  logic [DATA_W-1:0]   a_data,
    input  logic                b_valid,
    output logic                b_ready,
    input  logic [ADDR_W-1:0]   b_addr,
    input  logic [DATA_W-1:0]   b_data,
    output logic [NUM_REGS-1:0] en,
    output logic [DATA_W-1:0]   din,
    output logic [NUM_REGS-1:0] pend
);
    localparam logic [NUM_REGS-1:0] ONE = NUM_REGS'(1);
    logic                a_full_q, a_full_d, b_full_q, b_full_d, rr_q, rr_d;
    logic [ADDR_W-1:0]   a_addr_q, a_addr_d, b_addr_q, b_addr_d, g_addr;
    logic [DATA_W-1:0]   a_data_q, a_data_d, b_data_q, b_data_d, g_data, din_q, din_d;
    logic [NUM_REGS-1:0] en_q, en_d;
    logic                gnt_a, gnt_b, a_xfer, b_xfer;
    always_comb begin
        // rr_q set means B has priority on the next contention
        gnt_a    = a_full_q & (~b_full_q | ~rr_q);
        gnt_b    = b_full_q & ~gnt_a;
        a_ready  = ~a_full_q | gnt_a;
        b_ready  = ~b_full_q | gnt_b;
        a_xfer   = a_valid & a_ready;
        b_xfer   = b_valid & b_ready;
        a_full_d = a_xfer | (a_full_q & ~gnt_a);
        b_full_d = b_xfer | (b_full_q & ~gnt_b);
        a_addr_d = a_xfer ? a_addr : a_addr_q;
        a_data_d = a_xfer ? a_data : a_data_q;
        b_addr_d = b_xfer ? b_addr : b_addr_q;
        b_data_d = b_xfer ? b_data : b_data_q;
        rr_d     = gnt_a ? 1'b1 : gnt_b ? 1'b0 : rr_q;
        g_addr   = gnt_a ? a_addr_q : b_addr_q;
        g_data   = gnt_a ? a_data_q : b_data_q;
        en_d     = ((gnt_a | gnt_b) && g_addr != ADDR_W'(ZERO_REG)) ? ONE << g_addr : '0;
        din_d    = (gnt_a | gnt_b) ? g_data : din_q;
        pend     = ({NUM_REGS{a_full_q}} & (ONE << a_addr_q))
                 | ({NUM_REGS{b_full_q}} & (ONE << b_addr_q)) | en_q;
        pend[ZERO_REG] = 1'b0;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_full_q <= 1'b0;
            b_full_q <= 1'b0;
            rr_q     <= 1'b0;
            a_addr_q <= '0;
            a_data_q <= '0;
            b_addr_q <= '0;
            b_data_q <= '0;
            en_q     <= '0;
            din_q    <= '0;
        end else begin
            a_full_q <= a_full_d;
            b_full_q <= b_full_d;
            rr_q     <= rr_d;
            a_addr_q <= a_addr_d;
            a_data_q <= a_data_d;
            b_addr_q <= b_addr_d;
            b_data_q <= b_data_d;
            en_q     <= en_d;
            din_q    <= din_d;
        end
    end
    assign en  = en_q;
    assign din = din_q;
endmodule
